stopwatch_digits: RTL and testbench
===================================

# stopwatch_digits

- MM:SS BCD stopwatch that sits directly upstream of the seven-segment driver and feeds it through the `number` / `currLED` pair.
- Holds four BCD digit registers and a run/pause state machine driven by a debounced-level start/stop button and a clear pulse.
- Presents one digit at a time, one-hot tagged, and holds each long enough for the driver's own scan to latch it.

## Interface
- `TICK_CYCLES`, 100000000 — clk cycles per counted second.
- `tickBits`, 27 — prescaler width; must satisfy 2^tickBits > TICK_CYCLES.
- `DIGIT_HOLD`, 1600000 — clk cycles each digit is presented; must be ≥ the driver's full scan period.
- `holdBits`, 21 — scan counter width; must satisfy 2^holdBits > DIGIT_HOLD.
- `clk` in 1 — single clock; all logic is on the rising edge.
- `rst` in 1 — reset, asynchronous and active-low.
- `start_stop` in 1 — asynchronous button level; each rising edge toggles run/pause.
- `clear` in 1 — synchronous, active-high; zeroes the time and returns to IDLE.
- `number` out 4 — BCD value of the digit currently tagged by `currLED`.
- `currLED` out 4 — one-hot digit tag: 1000 = minutes tens, 0100 = minutes ones, 0010 = seconds tens, 0001 = seconds ones.
- `running` out 1 — high while in RUN.
- `wrap` out 1 — one-cycle pulse when the count wraps.

## Operation
- **States:** IDLE, RUN, PAUSE.
  - IDLE + start edge → RUN.
  - RUN + start edge → PAUSE.
  - PAUSE + start edge → RUN.
  - `clear` in any state → IDLE with all digits = 0.
- **Start edge detection:** two-flop synchronizer, then a registered previous value; edge = sync & ~prev.
- **Prescaler:**
  - Counts 0..TICK_CYCLES-1 only in RUN.
  - At TICK_CYCLES-1 it returns to 0 and issues an internal tick.
  - Frozen in PAUSE; zeroed in IDLE and on `clear`.
- **Tick increment:** d0 0..9, d1 0..5, d2 0..9, d3 0..9, with carry ripple in the same cycle. 59 s → d1 = d0 = 0, d2 + 1.
- **Wrap:** at 99:59 a tick gives 00:00, `wrap` = 1 for one cycle, and the state stays RUN.
- **Digit scan:**
  - Free-running in every state.
  - Scan counter counts 0..DIGIT_HOLD-1; at the terminal count `currLED` rotates right, 1000 → 0100 → 0010 → 0001 → 1000.
- **Digit output:** `number` is registered every clk from the digit selected by the current `currLED`, so a count change appears within one clk.
- **Simultaneous events:**
  - `clear` beats the start edge and the tick.
  - A start edge and a tick in the same cycle: the tick is applied, then the state toggles.
- **Reset mid-operation:** asserting `rst` returns every register to its reset value immediately. The scan restarts at 1000.

## Timing
- **Reset values:**
  - `number` = 0, `currLED` = 4'b1000, `running` = 0, `wrap` = 0.
  - Digits 0, state IDLE, both counters 0.
  - Synchronizer flops 0.
- **Start latency:** `start_stop` rising → state change and `running` update 3 clks later (2 sync stages + edge register).
- **`clear` latency:** digits and state take effect at the next edge. `number` reflects the zero one clk after that.
- **First tick after entering RUN:** exactly TICK_CYCLES clks later.
- **PAUSE/RUN:** resume continues the partially elapsed second.
- **Digit hold:** each `currLED` value is held for exactly DIGIT_HOLD clks.
- **`wrap`:** asserted in the same clk the digits become 00:00.

## Configuration
- `STOPWATCH_SATURATE_EN`
  - **Defined:** a tick at 99:59 holds the count at 99:59, pulses `wrap`, and forces PAUSE. A later start edge wraps the count to 00:00 and enters RUN.
  - **Undefined:** the count wraps to 00:00 and keeps running, as described in Operation.

## Structure
- **Package `stopwatch_pkg`:**
  - State enum: IDLE, RUN, PAUSE.
  - Digit limit constants: 9 and 5.
  - One-hot digit tag constants: 1000, 0100, 0010, 0001.
  - Default TICK_CYCLES and DIGIT_HOLD.
- **Sub-module `button_sync`:** two-flop synchronizer plus rising-edge detect, with an active-low asynchronous reset.
- **Top-level logic:** digit counters, state machine and scan mux.

## Test plan
- **Bench parameters:** TICK_CYCLES = 4, DIGIT_HOLD = 2.
- **Reset:** release `rst` → `currLED` = 1000, `number` = 0, `running` = 0; `currLED` reaches 0100 after 2 clks and 1000 again after 8 clks.
- **Start:** pulse `start_stop` → `running` = 1 after 3 clks; d0 = 1 after 4 more clks; after 60 ticks the tags read 1000:0, 0100:1, 0010:0, 0001:0.
- **Pause:** press at prescaler = 2 → PAUSE, count frozen for 100 clks; press again → the next tick arrives 2 clks after the resume state change.
- **Wrap:** preload by running 5999 ticks to reach 99:59; one more tick → 00:00 and a single-clk `wrap`. With `STOPWATCH_SATURATE_EN` → stays 99:59, `running` = 0.
- **Clear priority:** assert `clear` in the same clk as a tick and a start edge → IDLE, all digits 0, `running` = 0.
- **Async reset:** drop `rst` mid-RUN at 12:34 → all outputs return to their reset values without waiting for a clk edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: run/pause states, BCD digit limits,
// one-hot digit tags and default timing parameters.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    localparam logic [3:0] DIGIT_MAX9 = 4'd9;
    localparam logic [3:0] DIGIT_MAX5 = 4'd5;

    localparam logic [3:0] TAG_M10 = 4'b1000;
    localparam logic [3:0] TAG_M1  = 4'b0100;
    localparam logic [3:0] TAG_S10 = 4'b0010;
    localparam logic [3:0] TAG_S1  = 4'b0001;

    localparam int DEF_TICK_CYCLES = 100000000;
    localparam int DEF_DIGIT_HOLD  = 1600000;

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for an asynchronous button level followed by a rising-edge detect.
module button_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_rise
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/stopwatch_digits.sv
// MM:SS BCD stopwatch presenting one one-hot-tagged digit at a time to a seven-segment scanner.
// Define STOPWATCH_SATURATE_EN to hold at 99:59 and force PAUSE instead of wrapping to 00:00.
module stopwatch_digits
    import stopwatch_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES,
    parameter int tickBits    = 27,
    parameter int DIGIT_HOLD  = DEF_DIGIT_HOLD,
    parameter int holdBits    = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] number,
    output logic [3:0] currLED,
    output logic       running,
    output logic       wrap
);
    localparam logic [tickBits-1:0] TICK_LAST = tickBits'(TICK_CYCLES - 1);
    localparam logic [holdBits-1:0] HOLD_LAST = holdBits'(DIGIT_HOLD - 1);

    sw_state_e           r_state;
    logic [tickBits-1:0] r_presc;
    logic [holdBits-1:0] r_scan;
    logic [3:0]          r_digit [4];
    logic [3:0]          r_led;
    logic [3:0]          r_number;
    logic                r_running;
    logic                r_wrap;
`ifdef STOPWATCH_SATURATE_EN
    logic                r_sat;
`endif
    logic                w_start_edge;
    logic                w_tick;
    logic                w_at_max;
    logic [3:0]          w_at_lim;
    logic [3:0]          w_cin;
    logic [3:0]          w_next [4];
    logic [3:0]          w_sel;

    button_sync u_start (
        .clk    (clk),
        .rst_n  (rst),
        .i_btn  (start_stop),
        .o_rise (w_start_edge)
    );

    assign w_tick   = (r_presc == TICK_LAST);
    assign w_at_max = &w_at_lim;

    // Digit 0 is seconds ones; digit 1 (seconds tens) is the only one that rolls over at 5.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] LIM = (gi == 1) ? DIGIT_MAX5 : DIGIT_MAX9;
            assign w_at_lim[gi] = (r_digit[gi] == LIM);
            if (gi == 0) begin : g_c0
                assign w_cin[gi] = 1'b1;
            end else begin : g_cn
                assign w_cin[gi] = &w_at_lim[gi-1:0];
            end
            assign w_next[gi] = !w_cin[gi]   ? r_digit[gi] :
                                w_at_lim[gi] ? 4'd0        : r_digit[gi] + 4'd1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
            for (int i = 0; i < 4; i++) r_digit[i] <= 4'd0;
`ifdef STOPWATCH_SATURATE_EN
            r_sat     <= 1'b0;
`endif
        end else if (clear) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
            for (int i = 0; i < 4; i++) r_digit[i] <= 4'd0;
`ifdef STOPWATCH_SATURATE_EN
            r_sat     <= 1'b0;
`endif
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_presc <= '0;
                    if (w_start_edge) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // The tick is still applied when a start edge lands in the same cycle.
                    if (w_start_edge) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end
                    if (w_tick) begin
                        r_presc <= '0;
                        r_wrap  <= w_at_max;
`ifdef STOPWATCH_SATURATE_EN
                        if (w_at_max) begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                            r_sat     <= 1'b1;
                        end else begin
                            r_digit <= w_next;
                        end
`else
                        r_digit <= w_next;
`endif
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (w_start_edge) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
`ifdef STOPWATCH_SATURATE_EN
                        if (r_sat) begin
                            for (int i = 0; i < 4; i++) r_digit[i] <= 4'd0;
                            r_sat <= 1'b0;
                        end
`endif
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_sel = 4'd0;
        case (r_led)
            TAG_M10: w_sel = r_digit[3];
            TAG_M1:  w_sel = r_digit[2];
            TAG_S10: w_sel = r_digit[1];
            TAG_S1:  w_sel = r_digit[0];
            default: w_sel = 4'd0;
        endcase
    end

    // Scan runs in every state so the display keeps refreshing while idle or paused.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan   <= '0;
            r_led    <= TAG_M10;
            r_number <= 4'd0;
        end else begin
            if (r_scan == HOLD_LAST) begin
                r_scan <= '0;
                r_led  <= {r_led[0], r_led[3:1]};
            end else begin
                r_scan <= r_scan + 1'b1;
            end
            r_number <= w_sel;
        end
    end

    assign number  = r_number;
    assign currLED = r_led;
    assign running = r_running;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_stopwatch_digits.sv
// Bench for stopwatch_digits with TICK_CYCLES=4, DIGIT_HOLD=2: directed table, corner sequences
// and random button/clear activity against a seconds-count reference model.
module tb_stopwatch_digits;

    localparam int TICKS = 4;
    localparam int DHOLD = 2;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] number;
    logic [3:0] currLED;
    logic       running;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed time kept as a plain seconds count.
    int         m_secs, m_state, m_presc, m_cycle;
    logic       m_wrap, m_sat;
    logic [3:0] m_number, m_led;
    logic [2:0] hist;
    logic [3:0] rd [4];

    typedef struct {
        logic       st;
        logic       clr;
        logic [3:0] led;
        logic [3:0] num;
        logic       run;
        logic       wrp;
    } vec_t;
    vec_t tbl [16];

    stopwatch_digits #(
        .TICK_CYCLES (TICKS),
        .tickBits    (3),
        .DIGIT_HOLD  (DHOLD),
        .holdBits    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .number     (number),
        .currLED    (currLED),
        .running    (running),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic int digit_of(input int secs, input int idx);
        int mins;
        int s;
        mins = secs / 60;
        s    = secs % 60;
        case (idx)
            3:       return mins / 10;
            2:       return mins % 10;
            1:       return s / 10;
            default: return s % 10;
        endcase
    endfunction

    task automatic model_reset();
        m_secs = 0; m_state = S_IDLE; m_presc = 0; m_cycle = 0;
        m_wrap = 1'b0; m_sat = 1'b0; m_number = 4'd0; m_led = 4'b1000; hist = 3'b000;
    endtask

    task automatic model_edge();
        logic e;
        int   idx;
        e    = hist[1] & ~hist[2];
        hist = {hist[1:0], start_stop};
        idx  = 3 - ((m_cycle / DHOLD) % 4);
        m_number = 4'(digit_of(m_secs, idx));
        m_cycle++;
        m_led  = 4'b1000 >> ((m_cycle / DHOLD) % 4);
        m_wrap = 1'b0;
        if (clear) begin
            m_state = S_IDLE; m_secs = 0; m_presc = 0; m_sat = 1'b0;
        end else if (m_state == S_IDLE) begin
            m_presc = 0;
            if (e) m_state = S_RUN;
        end else if (m_state == S_RUN) begin
            if (e) m_state = S_PAUSE;
            if (m_presc == TICKS - 1) begin
                m_presc = 0;
                if (m_secs == 5999) begin
                    m_wrap = 1'b1;
`ifdef STOPWATCH_SATURATE_EN
                    m_state = S_PAUSE;
                    m_sat   = 1'b1;
`else
                    m_secs = 0;
`endif
                end else begin
                    m_secs++;
                end
            end else begin
                m_presc++;
            end
        end else begin
            if (e) begin
                m_state = S_RUN;
                if (m_sat) begin
                    m_secs = 0;
                    m_sat  = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        logic m_run;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        m_run = (m_state == S_RUN);
        checks++;
        if ({number, currLED, running, wrap} !== {m_number, m_led, m_run, m_wrap}) begin
            errors++;
            $display("FAIL model_cyc%0d: got num=%0d led=%b run=%b wrap=%b expected num=%0d led=%b run=%b wrap=%b",
                     m_cycle, number, currLED, running, wrap, m_number, m_led, m_run, m_wrap);
        end
    endtask

    task automatic press();
        start_stop = 1'b1;
        repeat (3) step();
        start_stop = 1'b0;
    endtask

    task automatic wait_secs(input int target);
        for (int n = 0; n < 30000 && m_secs != target; n++) step();
        chk("wait_secs", m_secs, target);
    endtask

    task automatic wait_presc(input int target);
        for (int n = 0; n < 64 && m_presc != target; n++) step();
        chk("wait_presc", m_presc, target);
    endtask

    // Records each digit from the second cycle its tag is held, when number matches the tag.
    task automatic read_time();
        logic [3:0] prev_led;
        for (int i = 0; i < 4; i++) rd[i] = 4'hF;
        prev_led = currLED;
        for (int n = 0; n < 10; n++) begin
            step();
            if (currLED == prev_led) begin
                case (currLED)
                    4'b1000: rd[3] = number;
                    4'b0100: rd[2] = number;
                    4'b0010: rd[1] = number;
                    4'b0001: rd[0] = number;
                    default: ;
                endcase
            end
            prev_led = currLED;
        end
    endtask

    task automatic chk_time(input string nm, input int m10, input int m1, input int s10, input int s1);
        read_time();
        chk({nm, "_m10"}, rd[3], m10);
        chk({nm, "_m1"},  rd[2], m1);
        chk({nm, "_s10"}, rd[1], s10);
        chk({nm, "_s1"},  rd[0], s1);
    endtask

    initial begin
        int wcnt;
        tbl[0]  = '{1'b1, 1'b0, 4'b1000, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 4'b0100, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 4'b0100, 4'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 4'b0010, 4'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 4'b0010, 4'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 4'b0001, 4'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 4'b0001, 4'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 4'b1000, 4'd1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 4'b1000, 4'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 4'b0100, 4'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 4'b0100, 4'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 4'b0010, 4'd0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 4'b0010, 4'd0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 4'b0001, 4'd0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 4'b0001, 4'd2, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 4'b1000, 4'd3, 1'b1, 1'b0};

        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_number",  number,  0);
        chk("reset_currLED", currLED, 4'b1000);
        chk("reset_running", running, 0);
        chk("reset_wrap",    wrap,    0);
        rst = 1'b1;

        // Start from reset: sync latency, first tick, digit scan order.
        for (int i = 0; i < 16; i++) begin
            start_stop = tbl[i].st;
            clear      = tbl[i].clr;
            step();
            checks++;
            if ({currLED, number, running, wrap} !== {tbl[i].led, tbl[i].num, tbl[i].run, tbl[i].wrp}) begin
                errors++;
                $display("FAIL table_row%0d: got led=%b num=%0d run=%b wrap=%b expected led=%b num=%0d run=%b wrap=%b",
                         i, currLED, number, running, wrap, tbl[i].led, tbl[i].num, tbl[i].run, tbl[i].wrp);
            end
        end

        // Pause lands on the 60th tick with the prescaler at 2; count freezes.
        wait_secs(59);
        wait_presc(3);
        press();
        chk("pause_running", running, 0);
        repeat (100) step();
        chk_time("pause_60s", 0, 1, 0, 0);
        press();
        chk("resume_running", running, 1);

        // Clear in the same cycle as a tick and a start edge.
        wait_presc(1);
        start_stop = 1'b1;
        step();
        step();
        clear = 1'b1;
        step();
        chk("clear_running", running, 0);
        clear = 1'b0;
        start_stop = 1'b0;
        chk_time("clear_zero", 0, 0, 0, 0);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(15) == 0) start_stop = ~start_stop;
            clear = ($urandom_range(199) == 0);
            step();
        end
        start_stop = 1'b0;
        clear = 1'b0;
        repeat (4) step();
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Count up to 99:59 and across the limit.
        press();
        chk("wrap_run_start", running, 1);
        wait_secs(5999);
        wcnt = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (wrap === 1'b1) wcnt++;
        end
        chk("wrap_pulses", wcnt, 1);
`ifdef STOPWATCH_SATURATE_EN
        chk("sat_running", running, 0);
        chk_time("sat_hold", 9, 9, 5, 9);
        press();
        chk("sat_resume_running", running, 1);
`else
        chk("wrap_running", running, 1);
`endif

        // Asynchronous reset mid-count at 12:34, between clock edges.
        wait_secs(754);
        #2 rst = 1'b0;
        #1;
        chk("areset_number",  number,  0);
        chk("areset_currLED", currLED, 4'b1000);
        chk("areset_running", running, 0);
        chk("areset_wrap",    wrap,    0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (20) step();
        chk_time("areset_zero", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
